// File: rtl/l0_instr_buffer_if.sv
// Fetch, response and L1i line channels of the L0 instruction buffer.
// slave is the buffer side, master is the core/L1 side.
interface l0_instr_buffer_if #(
   parameter int B = 64
);
   logic           flush_in;
   logic           fetch_valid_in;
   logic [63:0]    fetch_addr_in;
   logic           fetch_ready_out;
   logic           instr_valid_out;
   logic [31:0]    instr_out;
   logic [63:0]    instr_addr_out;
   logic           instr_ready_in;
   logic           l1_valid_out;
   logic           l1_ready_in;
   logic [63:0]    l1_addr_out;
   logic           l1_valid_in;
   logic           l1_ready_out;
   logic [63:0]    l1_addr_in;
   logic [8*B-1:0] l1_value_in;

   modport slave (
      input  flush_in, fetch_valid_in, fetch_addr_in, instr_ready_in,
             l1_ready_in, l1_valid_in, l1_addr_in, l1_value_in,
      output fetch_ready_out, instr_valid_out, instr_out, instr_addr_out,
             l1_valid_out, l1_addr_out, l1_ready_out
   );

   modport master (
      output flush_in, fetch_valid_in, fetch_addr_in, instr_ready_in,
             l1_ready_in, l1_valid_in, l1_addr_in, l1_value_in,
      input  fetch_ready_out, instr_valid_out, instr_out, instr_addr_out,
             l1_valid_out, l1_addr_out, l1_ready_out
   );
endinterface

// File: rtl/l0_instr_buffer.sv
// Fully-associative L0 instruction line buffer: hit answers 1 cycle after accept, miss fetches one line from L1i.
// One request in flight; fetch is refused outside IDLE and the response is held until instr_ready_in.
module l0_instr_buffer #(
   parameter int NUM_LINES = 4,
   parameter int B         = 64
) (
   input  logic             clk_in,
   input  logic             rst_N_in,
   l0_instr_buffer_if.slave bus
);
   localparam int OFS = $clog2(B);
   localparam int TW  = 64 - OFS;
   localparam int WW  = OFS - 2;
   localparam int PW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

   typedef enum logic [1:0] {IDLE, RESPOND, MISS_REQ, MISS_WAIT} state_t;

   state_t               state_q;
   logic [NUM_LINES-1:0] valid_q;
   logic [TW-1:0]        tag_q  [NUM_LINES];
   logic [8*B-1:0]       data_q [NUM_LINES];
   logic [PW-1:0]        rr_q;
   logic [61:0]          pend_q;
   logic                 abort_q;
   logic                 instr_vld_q;
   logic [31:0]          instr_dat_q;
   logic [61:0]          instr_addr_q;
   logic                 l1_vld_q;
   logic [TW-1:0]        l1_tag_q;
   logic                 l1_rdy_q;

   logic                 fetch_fire;
   logic                 resp_fire;
   logic                 resp_match;
   logic                 install;
   logic                 hit;
   logic [PW-1:0]        hit_idx;
   logic [PW-1:0]        victim;
   logic [TW-1:0]        fetch_tag;
   logic [TW-1:0]        resp_tag;
   logic [WW-1:0]        fetch_word;
   logic [WW-1:0]        pend_word;
   logic [8*B-1:0]       hit_line;
   logic [31:0]          hit_word;
   logic [31:0]          resp_word;
   logic                 unused_bits;

   assign fetch_tag  = bus.fetch_addr_in[63:OFS];
   assign fetch_word = bus.fetch_addr_in[OFS-1:2];
   assign resp_tag   = bus.l1_addr_in[63:OFS];
   assign pend_word  = pend_q[WW-1:0];
   assign unused_bits = ^{bus.fetch_addr_in[1:0], bus.l1_addr_in[OFS-1:0]};

   assign fetch_fire = bus.fetch_valid_in & bus.fetch_ready_out;
   assign resp_fire  = bus.l1_valid_in & bus.l1_ready_out;
   assign resp_match = (resp_tag == pend_q[61:WW]);
   // A flush or an earlier abort turns the matching response into a plain drain.
   assign install    = (state_q == MISS_WAIT) & resp_fire & resp_match & ~abort_q & ~bus.flush_in;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (valid_q[i] && (tag_q[i] == fetch_tag)) begin
            hit     = 1'b1;
            hit_idx = PW'(i);
         end
      end
   end

   always_comb begin
      victim = rr_q;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (!valid_q[i]) victim = PW'(i);
      end
   end

   assign hit_line  = data_q[hit_idx];
   assign hit_word  = hit_line[{fetch_word, 5'b0} +: 32];
   // Miss data is forwarded straight from the returning line.
   assign resp_word = bus.l1_value_in[{pend_word, 5'b0} +: 32];

   assign bus.fetch_ready_out = (state_q == IDLE) & rst_N_in & ~bus.flush_in;
   assign bus.instr_valid_out = instr_vld_q;
   assign bus.instr_out       = instr_dat_q;
   assign bus.instr_addr_out  = {instr_addr_q, 2'b00};
   assign bus.l1_valid_out    = l1_vld_q;
   assign bus.l1_addr_out     = {l1_tag_q, {OFS{1'b0}}};
   assign bus.l1_ready_out    = l1_rdy_q;

   always_ff @(posedge clk_in) begin
      if (install) begin
         tag_q[victim]  <= resp_tag;
         data_q[victim] <= bus.l1_value_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         rr_q         <= '0;
         pend_q       <= '0;
         abort_q      <= 1'b0;
         instr_vld_q  <= 1'b0;
         instr_dat_q  <= '0;
         instr_addr_q <= '0;
         l1_vld_q     <= 1'b0;
         l1_tag_q     <= '0;
         l1_rdy_q     <= 1'b0;
      end else begin
         if (bus.flush_in) begin
            valid_q <= '0;
         end else if (install) begin
            valid_q[victim] <= 1'b1;
         end
         if (install) begin
            rr_q <= (rr_q == PW'(NUM_LINES - 1)) ? '0 : rr_q + PW'(1);
         end

         case (state_q)
            IDLE: begin
               if (fetch_fire) begin
                  pend_q  <= bus.fetch_addr_in[63:2];
                  abort_q <= 1'b0;
                  if (hit) begin
                     instr_vld_q  <= 1'b1;
                     instr_dat_q  <= hit_word;
                     instr_addr_q <= bus.fetch_addr_in[63:2];
                     state_q      <= RESPOND;
                  end else begin
                     l1_vld_q <= 1'b1;
                     l1_tag_q <= fetch_tag;
                     state_q  <= MISS_REQ;
                  end
               end
            end
            RESPOND: begin
               if (bus.flush_in || bus.instr_ready_in) begin
                  instr_vld_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            MISS_REQ: begin
               if (bus.flush_in) abort_q <= 1'b1;
               if (bus.l1_ready_in) begin
                  l1_vld_q <= 1'b0;
                  l1_rdy_q <= 1'b1;
                  state_q  <= MISS_WAIT;
               end
            end
            MISS_WAIT: begin
               if (resp_fire) begin
                  if (abort_q || bus.flush_in) begin
                     l1_rdy_q <= 1'b0;
                     state_q  <= IDLE;
                  end else if (resp_match) begin
                     l1_rdy_q     <= 1'b0;
                     instr_vld_q  <= 1'b1;
                     instr_dat_q  <= resp_word;
                     instr_addr_q <= pend_q;
                     state_q      <= RESPOND;
                  end
               end else if (bus.flush_in) begin
                  abort_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_l0_instr_buffer.sv
// Directed bench for l0_instr_buffer: cache-content model plus per-cycle output compare.
// Line data comes from a fixed address->word function, so expected words never depend on the DUT.
module tb_l0_instr_buffer;
   logic clk_in;
   logic rst_N_in;

   l0_instr_buffer_if #(.B(64)) bus ();

   l0_instr_buffer #(.NUM_LINES(4), .B(64)) dut (
      .clk_in   (clk_in),
      .rst_N_in (rst_N_in),
      .bus      (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Expected outputs for the cycle after the most recent rising edge.
   logic        exp_frdy, exp_ivld, exp_l1vld, exp_l1rdy;
   logic [31:0] exp_idat;
   logic [63:0] exp_iaddr, exp_l1addr;

   // Cache content model.
   logic [57:0] m_tag [4];
   bit          m_vld [4];
   int          m_rr;
   logic [63:0] p_addr;
   bit          p_abort;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [57:0] ln;
      logic [3:0]  k;
      ln = a[63:6];
      k  = a[5:2];
      if (ln == 58'h40 && k == 4'd2) return 32'hDEADBEEF;
      return {ln[19:0], 8'hC0, k};
   endfunction

   function automatic logic [511:0] gen_line(input logic [63:0] a);
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = mem_word({a[63:6], 6'(k * 4)});
      return l;
   endfunction

   function automatic bit m_hit(input logic [57:0] t);
      for (int i = 0; i < 4; i++) if (m_vld[i] && m_tag[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void m_install(input logic [57:0] t);
      int v;
      v = -1;
      for (int i = 0; i < 4 && v < 0; i++) if (!m_vld[i]) v = i;
      if (v < 0) v = m_rr;
      m_tag[v] = t;
      m_vld[v] = 1'b1;
      m_rr = (m_rr + 1) % 4;
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
   endfunction

   always @(negedge clk_in) begin
      if (chk_en) begin
         chk("fetch_ready", 64'(bus.fetch_ready_out), 64'(exp_frdy & rst_N_in & ~bus.flush_in));
         chk("instr_valid", 64'(bus.instr_valid_out), 64'(exp_ivld));
         if (exp_ivld) begin
            chk("instr_out", 64'(bus.instr_out), 64'(exp_idat));
            chk("instr_addr", bus.instr_addr_out, exp_iaddr);
         end
         chk("l1_valid", 64'(bus.l1_valid_out), 64'(exp_l1vld));
         if (exp_l1vld) chk("l1_addr", bus.l1_addr_out, exp_l1addr);
         chk("l1_ready", 64'(bus.l1_ready_out), 64'(exp_l1rdy));
         if (!rst_N_in) begin
            chk("rst_instr_out", 64'(bus.instr_out), 64'h0);
            chk("rst_instr_addr", bus.instr_addr_out, 64'h0);
            chk("rst_l1_addr", bus.l1_addr_out, 64'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      bus.flush_in       = 1'b0;
      bus.fetch_valid_in = 1'b0;
      bus.fetch_addr_in  = '0;
      bus.instr_ready_in = 1'b0;
      bus.l1_ready_in    = 1'b0;
      bus.l1_valid_in    = 1'b0;
      bus.l1_addr_in     = '0;
      bus.l1_value_in    = '0;
      rst_N_in  = 1'b0;
      exp_frdy  = 1'b0;
      exp_ivld  = 1'b0;
      exp_l1vld = 1'b0;
      exp_l1rdy = 1'b0;
      m_clear();
      m_rr    = 0;
      p_abort = 1'b0;
      repeat (3) tick();
      rst_N_in = 1'b1;
      exp_frdy = 1'b1;
   endtask

   task automatic do_fetch(input logic [63:0] a, output bit was_hit);
      bus.fetch_valid_in = 1'b1;
      bus.fetch_addr_in  = a;
      tick();
      bus.fetch_valid_in = 1'b0;
      was_hit  = m_hit(a[63:6]);
      exp_frdy = 1'b0;
      if (was_hit) begin
         exp_ivld  = 1'b1;
         exp_idat  = mem_word(a);
         exp_iaddr = {a[63:2], 2'b00};
      end else begin
         exp_l1vld  = 1'b1;
         exp_l1addr = {a[63:6], 6'b0};
         p_addr     = a;
         p_abort    = 1'b0;
      end
   endtask

   task automatic l1_accept(input int delay);
      repeat (delay) tick();
      bus.l1_ready_in = 1'b1;
      tick();
      bus.l1_ready_in = 1'b0;
      exp_l1vld = 1'b0;
      exp_l1rdy = 1'b1;
   endtask

   task automatic l1_return(input logic [63:0] a);
      bus.l1_valid_in = 1'b1;
      bus.l1_addr_in  = a;
      bus.l1_value_in = gen_line(a);
      tick();
      bus.l1_valid_in = 1'b0;
      if (p_abort) begin
         exp_l1rdy = 1'b0;
         exp_frdy  = 1'b1;
         p_abort   = 1'b0;
      end else if (a[63:6] == p_addr[63:6]) begin
         m_install(a[63:6]);
         exp_l1rdy = 1'b0;
         exp_ivld  = 1'b1;
         exp_idat  = mem_word(p_addr);
         exp_iaddr = {p_addr[63:2], 2'b00};
      end
   endtask

   task automatic consume(input int hold);
      bus.instr_ready_in = 1'b0;
      repeat (hold) tick();
      bus.instr_ready_in = 1'b1;
      tick();
      bus.instr_ready_in = 1'b0;
      exp_ivld = 1'b0;
      exp_frdy = 1'b1;
   endtask

   task automatic flush_cycle();
      bus.flush_in = 1'b1;
      tick();
      bus.flush_in = 1'b0;
      m_clear();
      if (exp_ivld) begin
         exp_ivld = 1'b0;
         exp_frdy = 1'b1;
      end
      if (exp_l1vld || exp_l1rdy) p_abort = 1'b1;
   endtask

   task automatic serve(input logic [63:0] a);
      bit h;
      do_fetch(a, h);
      if (!h) begin
         l1_accept(0);
         l1_return(a);
      end
      consume(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit h;
      do_reset();
      rst_N_in = 1'b0;
      exp_frdy = 1'b0;
      chk_en   = 1;
      @(negedge clk_in);
      chk("reset_fetch_ready", 64'(bus.fetch_ready_out), 64'h0);
      tick();
      rst_N_in = 1'b1;
      exp_frdy = 1'b1;
      @(negedge clk_in);
      chk("release_fetch_ready", 64'(bus.fetch_ready_out), 64'h1);

      // Cold miss with a delayed L1 grant.
      do_fetch(64'h1008, h);
      @(negedge clk_in);
      chk("cold_l1_addr", bus.l1_addr_out, 64'h1000);
      l1_accept(2);
      l1_return(64'h1000);
      @(negedge clk_in);
      chk("cold_instr", 64'(bus.instr_out), 64'hDEADBEEF);
      chk("cold_iaddr", bus.instr_addr_out, 64'h1008);
      consume(0);

      // Hit, then 5 cycles of back-pressure with a competing fetch held high.
      do_fetch(64'h103C, h);
      @(negedge clk_in);
      chk("hit_latency", 64'(bus.instr_valid_out), 64'h1);
      chk("hit_word15", 64'(bus.instr_out), 64'h00040C0F);
      chk("hit_no_l1", 64'(bus.l1_valid_out), 64'h0);
      bus.fetch_valid_in = 1'b1;
      bus.fetch_addr_in  = 64'h2000;
      consume(5);
      bus.fetch_valid_in = 1'b0;

      // Flush in MISS_WAIT: the line is drained, not installed.
      do_fetch(64'h5000, h);
      l1_accept(0);
      flush_cycle();
      l1_return(64'h5000);
      @(negedge clk_in);
      chk("flush_no_resp", 64'(bus.instr_valid_out), 64'h0);
      do_fetch(64'h5000, h);
      @(negedge clk_in);
      chk("flush_refetch_miss", 64'(bus.l1_valid_out), 64'h1);
      l1_accept(0);
      l1_return(64'h5000);
      consume(0);

      // Mismatched response is dropped, the right one is served.
      do_fetch(64'h6008, h);
      l1_accept(1);
      l1_return(64'h7000);
      @(negedge clk_in);
      chk("mismatch_still_wait", 64'(bus.l1_ready_out), 64'h1);
      chk("mismatch_no_resp", 64'(bus.instr_valid_out), 64'h0);
      l1_return(64'h6000);
      @(negedge clk_in);
      chk("match_word", 64'(bus.instr_out), 64'h00180C02);
      consume(0);
      serve(64'h6008);
      serve(64'h7004);

      // Flush while responding, then flush while the request is still unaccepted.
      do_fetch(64'h6004, h);
      flush_cycle();
      serve(64'h6004);
      do_fetch(64'h8000, h);
      flush_cycle();
      l1_accept(0);
      l1_return(64'h8000);

      // Replacement from a clean reset.
      do_reset();
      serve(64'h0000);
      serve(64'h1000);
      serve(64'h2000);
      serve(64'h3000);
      serve(64'h4000);
      do_fetch(64'h0000, h);
      @(negedge clk_in);
      chk("evict_refetch_req", 64'(bus.l1_valid_out), 64'h1);
      chk("evict_refetch_addr", bus.l1_addr_out, 64'h0);
      l1_accept(0);
      l1_return(64'h0000);
      consume(0);
      do_fetch(64'h2010, h);
      @(negedge clk_in);
      chk("survivor_hit", 64'(bus.instr_valid_out), 64'h1);
      consume(0);

      // Reset mid-miss: the late response is not accepted.
      do_fetch(64'h9000, h);
      l1_accept(0);
      do_reset();
      bus.l1_valid_in = 1'b1;
      bus.l1_addr_in  = 64'h9000;
      bus.l1_value_in = gen_line(64'h9000);
      tick();
      @(negedge clk_in);
      chk("late_resp_refused", 64'(bus.l1_ready_out), 64'h0);
      tick();
      bus.l1_valid_in = 1'b0;
      serve(64'h9000);

      tick();
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/l0_instr_buffer.md
L0_INSTR_BUFFER -- requirements
Module: l0_instr_buffer

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, the number of fully-associative 64-byte lines held.
REQ-002 SHALL have parameter B, default 64, the line size in bytes; line data width is 8*B.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_N_in, input, 1, the reset; asynchronous and active-low.
REQ-005 SHALL have port flush_in, input, 1, the synchronous invalidate of all lines and abort of any pending fetch.
REQ-006 SHALL have port fetch_valid_in, input, 1, fetch request valid.
REQ-007 SHALL have port fetch_addr_in, input, 64, fetch byte address; bits [1:0] ignored.
REQ-008 SHALL have port fetch_ready_out, output, 1, buffer accepts a fetch this cycle.
REQ-009 SHALL have port instr_valid_out, output, 1, instruction response valid.
REQ-010 SHALL have port instr_out, output, 32, instruction word.
REQ-011 SHALL have port instr_addr_out, output, 64, address of instr_out, bits [1:0] forced 0.
REQ-012 SHALL have port instr_ready_in, input, 1, consumer accepts the response.
REQ-013 SHALL have port l1_valid_out, output, 1, line request to L1i valid.
REQ-014 SHALL have port l1_ready_in, input, 1, L1i accepts the line request.
REQ-015 SHALL have port l1_addr_out, output, 64, line-aligned request address (bits [5:0] = 0).
REQ-016 SHALL have port l1_valid_in, input, 1, line response from L1i valid.
REQ-017 SHALL have port l1_ready_out, output, 1, buffer accepts a line response.
REQ-018 SHALL have port l1_addr_in, input, 64, address of the returned line.
REQ-019 SHALL have port l1_value_in, input, 8*B, returned line data.

Function
REQ-020 SHALL implement an FSM with states IDLE, RESPOND, MISS_REQ, MISS_WAIT.
REQ-021 SHALL transfer on any channel only in a cycle where its valid and ready are both high.
REQ-022 SHALL drive fetch_ready_out high only in IDLE and never when flush_in is high.
REQ-023 SHALL, on an accepted fetch whose tag fetch_addr_in[63:6] matches a valid line, go to RESPOND with instr_valid_out high the next cycle (hit latency 1).
REQ-024 SHALL select instr_out = line[32*w +: 32] where w = fetch_addr_in[5:2].
REQ-025 SHALL hold instr_valid_out, instr_out, instr_addr_out stable in RESPOND until instr_ready_in, then return to IDLE.
REQ-026 SHALL, on an accepted missing fetch, go to MISS_REQ and drive l1_valid_out with l1_addr_out = {fetch_addr[63:6], 6'b0} held stable until l1_ready_in.
REQ-027 SHALL, on l1_ready_in in MISS_REQ, deassert l1_valid_out and go to MISS_WAIT, driving l1_ready_out high only in MISS_WAIT.
REQ-028 SHALL, on l1_valid_in with l1_addr_in[63:6] equal to the pending tag, install the line in the victim slot, then go to RESPOND serving the pending word the next cycle.
REQ-029 SHALL consume and discard an L1 response whose tag mismatches, remaining in MISS_WAIT.
REQ-030 SHALL choose the victim as the first invalid line (lowest index), otherwise a round-robin pointer that advances by 1 modulo NUM_LINES on each install.
REQ-031 SHALL, on flush_in, clear all valid bits and drop any RESPOND response (instr_valid_out low the next cycle, go IDLE).
REQ-032 SHALL, on flush_in in MISS_REQ, finish the L1 request handshake, and in MISS_WAIT, still consume the response without installing it or responding, then go IDLE.
REQ-033 SHALL never hold more than one outstanding L1 request.
REQ-034 SHALL serve a hit and an install from the same line data in the same cycle if both occur (install data is forwarded).

Reset
REQ-035 SHALL, on rst_N_in low, immediately set state IDLE, all valid bits 0, and the round-robin pointer 0.
REQ-036 SHALL, on rst_N_in low, drive all outputs 0 (fetch_ready_out 0 during reset, 1 the first cycle after release), including instr_out, instr_addr_out and l1_addr_out.
REQ-037 SHALL, on reset asserted mid-miss, abandon the transaction; any later L1 response arriving in IDLE is not accepted (l1_ready_out 0).

Verification
REQ-038 Cold miss: fetch 0x1008 -> l1_addr_out 0x1000; return line word2 = 0xDEADBEEF -> instr_out 0xDEADBEEF, instr_addr_out 0x1008.
REQ-039 Hit: after REQ-038, fetch 0x103C -> instr_valid_out one cycle after accept, instr_out = word15, no l1_valid_out.
REQ-040 Replacement: fill lines 0x0000,0x1000,0x2000,0x3000, fetch 0x4000 -> evicts 0x0000; refetch 0x0000 -> new L1 request.
REQ-041 Back-pressure: hold instr_ready_in 0 for 5 cycles -> outputs stable, fetch_ready_out 0 throughout.
REQ-042 Flush in MISS_WAIT: flush then return line 0x5000 -> l1_ready_out accepts, no instr_valid_out, refetch 0x5000 misses.
REQ-043 Mismatched response: pending 0x6000, return 0x7000 then 0x6000 -> first dropped, second installed and served.
